// File: rtl/tau_pkg.sv
// tau_pkg: shared types and defaults for the tau core sequencer.
// Holds the exec_driver state enum, the halt opcode and the default widths.
// EXEC_DRIVER_STEP_EN adds the STEP_WAIT state to the enum.
package tau_pkg;

  localparam int TAU_OPCODE_SIZE = 8;
  localparam int TAU_ADDR_WIDTH  = 8;
  localparam int TAU_CNT_WIDTH   = 16;

  localparam logic [7:0] HALT_OPCODE = 8'h01;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_HALTED    = 3'd4
`ifdef EXEC_DRIVER_STEP_EN
    ,
    S_STEP_WAIT = 3'd5
`endif
  } exec_state_t;

endpackage

// File: rtl/exec_driver.sv
// exec_driver: fetch/decode/execute sequencer for the tau core; owns PC, IR and retired count.
// Latency: 3 cycles per instruction minimum (FETCH, DECODE, EXECUTE); halted rises 2 cycles after the halt fetch_ack.
// Backpressure: fetch_req held until fetch_ack, exec_valid held until exec_done; nothing is buffered.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start / resume             pulses leaving IDLE / HALTED (and STEP_WAIT)
//   fetch_req/addr/ack/data    instruction memory handshake, fetch_addr == pc
//   ir, run_ok                 instruction register out, halt decoder verdict in (0 = halt)
//   exec_valid/exec_done       execute datapath handshake
//   branch_taken/target        next-PC override, sampled with exec_done
//   pc, halted, retired        program counter, halt status, completed instruction count
// Optional: EXEC_DRIVER_STEP_EN adds input step_mode and the STEP_WAIT single-step state.
module exec_driver
  import tau_pkg::*;
#(
  parameter int OPCODE_SIZE = TAU_OPCODE_SIZE,
  parameter int ADDR_WIDTH  = TAU_ADDR_WIDTH,
  parameter int CNT_WIDTH   = TAU_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   resume,
`ifdef EXEC_DRIVER_STEP_EN
  input  logic                   step_mode,
`endif
  output logic                   fetch_req,
  output logic [ADDR_WIDTH-1:0]  fetch_addr,
  input  logic                   fetch_ack,
  input  logic [OPCODE_SIZE-1:0] fetch_data,
  output logic [OPCODE_SIZE-1:0] ir,
  input  logic                   run_ok,
  output logic                   exec_valid,
  input  logic                   exec_done,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_target,
  output logic [ADDR_WIDTH-1:0]  pc,
  output logic                   halted,
  output logic [CNT_WIDTH-1:0]   retired
);

  exec_state_t state, state_nxt;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (start)     state_nxt = S_FETCH;
      S_FETCH:   if (fetch_ack) state_nxt = S_DECODE;
      // run_ok is the decoder's view of the IR loaded on the previous edge
      S_DECODE:  state_nxt = run_ok ? S_EXECUTE : S_HALTED;
      S_EXECUTE: begin
        if (exec_done) begin
`ifdef EXEC_DRIVER_STEP_EN
          state_nxt = step_mode ? S_STEP_WAIT : S_FETCH;
`else
          state_nxt = S_FETCH;
`endif
        end
      end
      S_HALTED:  if (resume) state_nxt = S_FETCH;
`ifdef EXEC_DRIVER_STEP_EN
      S_STEP_WAIT: if (resume) state_nxt = S_FETCH;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: decoded from state only, so reset drops them asynchronously
  always_comb begin
    fetch_req  = (state == S_FETCH);
    exec_valid = (state == S_EXECUTE);
`ifdef EXEC_DRIVER_STEP_EN
    halted     = (state == S_HALTED) || (state == S_STEP_WAIT);
`else
    halted     = (state == S_HALTED);
`endif
  end

  assign fetch_addr = pc;

  // PC / IR / retired counter. A halt leaves pc on the halt instruction;
  // resume from HALTED steps past it. Resume from STEP_WAIT does not touch pc,
  // which already advanced when the instruction completed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      if (state == S_FETCH && fetch_ack)
        ir <= fetch_data;
      if (state == S_EXECUTE && exec_done) begin
        pc      <= branch_taken ? branch_target : pc + ADDR_WIDTH'(1);
        retired <= retired + CNT_WIDTH'(1);
      end
      if (state == S_HALTED && resume)
        pc <= pc + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_exec_driver.sv
// tb_exec_driver: directed and randomized bench for exec_driver.
// The halt decoder is modelled here as run_ok = (ir != HALT_OPCODE).
// EXEC_DRIVER_STEP_EN enables the single-step scenario.
module tb_exec_driver;
  import tau_pkg::*;

  localparam int OW = 8;
  localparam int AW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          resume = 1'b0;
  logic          fetch_ack = 1'b0;
  logic [OW-1:0] fetch_data = '0;
  logic          exec_done = 1'b0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
`ifdef EXEC_DRIVER_STEP_EN
  logic          step_mode = 1'b0;
`endif
  logic          fetch_req, exec_valid, halted, run_ok;
  logic [AW-1:0] fetch_addr, pc;
  logic [OW-1:0] ir;
  logic [CW-1:0] retired;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Behavioural halt decoder
  assign run_ok = (ir != HALT_OPCODE);

  exec_driver #(.OPCODE_SIZE(OW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .resume(resume),
`ifdef EXEC_DRIVER_STEP_EN
    .step_mode(step_mode),
`endif
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
    .fetch_data(fetch_data), .ir(ir), .run_ok(run_ok), .exec_valid(exec_valid),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .halted(halted), .retired(retired)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    start = 0; resume = 0; fetch_ack = 0; exec_done = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  task automatic ack_with(input logic [OW-1:0] d);
    fetch_data = d; fetch_ack = 1; tick(); fetch_ack = 0;
  endtask

  task automatic done_with(input logic br, input logic [AW-1:0] tgt);
    exec_done = 1; branch_taken = br; branch_target = tgt; tick();
    exec_done = 0; branch_taken = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (fetch_req !== 1'b0 || exec_valid !== 1'b0 || halted !== 1'b0 ||
        pc !== 8'h00 || ir !== 8'h00 || retired !== 16'h0000)
      $display("FAIL reset_state: req=%b ev=%b halt=%b pc=%h ir=%h ret=%h, want all zero",
               fetch_req, exec_valid, halted, pc, ir, retired);
    else passes++;
  endtask

  task automatic test_basic_halt();
    logic [OW-1:0] prog [3];
    prog = '{8'h10, 8'h20, 8'h01};
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== AW'(i))
        $display("FAIL basic_fetch%0d: req=%b addr=%h, want req=1 addr=%h", i, fetch_req, fetch_addr, AW'(i));
      else passes++;
      ack_with(prog[i]);
      if (i == 2) begin
        checks++;
        if (halted !== 1'b0) $display("FAIL halt_early: halted=%b in decode, want 0", halted);
        else passes++;
      end
      tick();
      if (i < 2) done_with(1'b0, 8'h00);
    end
    checks++;
    if (halted !== 1'b1 || pc !== 8'h02 || retired !== 16'd2 || fetch_req !== 1'b0)
      $display("FAIL basic_halt: halted=%b pc=%h ret=%0d req=%b, want 1 02 2 0", halted, pc, retired, fetch_req);
    else passes++;
  endtask

  task automatic test_resume();
    resume = 1; tick(); resume = 0;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 8'h03 || halted !== 1'b0)
      $display("FAIL resume: req=%b addr=%h halted=%b, want 1 03 0", fetch_req, fetch_addr, halted);
    else passes++;
  endtask

  task automatic test_delayed_ack();
    for (int k = 0; k < 4; k++) begin
      fetch_data = 8'($urandom);
      tick();
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== 8'h03 || ir !== 8'h01)
        $display("FAIL delayed_ack_hold%0d: req=%b addr=%h ir=%h, want 1 03 01", k, fetch_req, fetch_addr, ir);
      else passes++;
    end
    ack_with(8'h55);
    checks++;
    if (ir !== 8'h55 || fetch_req !== 1'b0)
      $display("FAIL delayed_ack_load: ir=%h req=%b, want 55 0", ir, fetch_req);
    else passes++;
  endtask

  task automatic test_branch_wrap();
    tick();
    checks++;
    if (exec_valid !== 1'b1) $display("FAIL exec_valid: got %b want 1", exec_valid);
    else passes++;
    done_with(1'b1, 8'h40);
    checks++;
    if (fetch_addr !== 8'h40 || retired !== 16'd3)
      $display("FAIL branch_taken: addr=%h ret=%0d, want 40 3", fetch_addr, retired);
    else passes++;
    ack_with(8'h22); tick(); done_with(1'b1, 8'hFF);
    checks++;
    if (fetch_addr !== 8'hFF) $display("FAIL branch_ff: addr=%h want ff", fetch_addr);
    else passes++;
    ack_with(8'h33); tick(); done_with(1'b0, 8'h77);
    checks++;
    if (fetch_addr !== 8'h00 || retired !== 16'd5)
      $display("FAIL pc_wrap: addr=%h ret=%0d, want 00 5", fetch_addr, retired);
    else passes++;
  endtask

  task automatic test_async_reset();
    ack_with(8'h44); tick(); tick(); tick();
    checks++;
    if (exec_valid !== 1'b1) $display("FAIL exec_hold: exec_valid=%b want 1", exec_valid);
    else passes++;
    #2 rst_n = 0;
    #1;
    checks++;
    if (exec_valid !== 1'b0 || pc !== 8'h00 || retired !== 16'h0000 || ir !== 8'h00)
      $display("FAIL async_reset_exec: ev=%b pc=%h ret=%h ir=%h, want 0 00 0000 00", exec_valid, pc, retired, ir);
    else passes++;
    tick();
    rst_n = 1;
    exec_done = 1; resume = 1; fetch_ack = 1; fetch_data = 8'h99;
    tick(); tick();
    clear_inputs();
    checks++;
    if (fetch_req !== 1'b0 || exec_valid !== 1'b0 || halted !== 1'b0 || pc !== 8'h00 ||
        retired !== 16'h0000 || ir !== 8'h00)
      $display("FAIL idle_ignore: req=%b ev=%b halt=%b pc=%h ret=%h ir=%h, want all zero",
               fetch_req, exec_valid, halted, pc, retired, ir);
    else passes++;
    start = 1; tick(); start = 0;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 8'h00)
      $display("FAIL restart: req=%b addr=%h, want 1 00", fetch_req, fetch_addr);
    else passes++;
    #2 rst_n = 0;
    #1;
    checks++;
    if (fetch_req !== 1'b0) $display("FAIL async_reset_fetch: req=%b want 0", fetch_req);
    else passes++;
    tick();
    rst_n = 1;
    tick();
  endtask

  // Instruction-level reference: memory image, expected pc and retired count.
  task automatic test_random();
    logic [OW-1:0] mem [256];
    logic [AW-1:0] m_pc;
    logic [CW-1:0] m_ret;
    logic          br;
    logic [AW-1:0] tgt;
    for (int a = 0; a < 256; a++)
      mem[a] = ($urandom_range(0, 4) == 0) ? HALT_OPCODE : 8'($urandom);
    do_reset();
    start = 1; tick(); start = 0;
    m_pc = '0; m_ret = '0;
    for (int n = 0; n < 200; n++) begin
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== m_pc)
        $display("FAIL rnd_fetch%0d: req=%b addr=%h, want 1 %h", n, fetch_req, fetch_addr, m_pc);
      else passes++;
      repeat ($urandom_range(0, 3)) begin
        fetch_data = 8'($urandom); exec_done = 1'($urandom); resume = 1'($urandom); start = 1'($urandom);
        tick();
      end
      clear_inputs();
      ack_with(mem[m_pc]);
      checks++;
      if (ir !== mem[m_pc]) $display("FAIL rnd_ir%0d: ir=%h want %h", n, ir, mem[m_pc]);
      else passes++;
      tick();
      if (mem[m_pc] == HALT_OPCODE) begin
        checks++;
        if (halted !== 1'b1 || pc !== m_pc || retired !== m_ret || fetch_req !== 1'b0)
          $display("FAIL rnd_halt%0d: halted=%b pc=%h ret=%h req=%b, want 1 %h %h 0",
                   n, halted, pc, retired, fetch_req, m_pc, m_ret);
        else passes++;
        repeat ($urandom_range(0, 2)) begin
          fetch_ack = 1'($urandom); fetch_data = 8'($urandom); exec_done = 1'($urandom); start = 1'($urandom);
          tick();
        end
        clear_inputs();
        resume = 1; tick(); resume = 0;
        m_pc = m_pc + 8'd1;
      end else begin
        repeat ($urandom_range(0, 3)) begin
          fetch_ack = 1'($urandom); fetch_data = 8'($urandom); resume = 1'($urandom); start = 1'($urandom);
          tick();
        end
        clear_inputs();
        checks++;
        if (exec_valid !== 1'b1 || halted !== 1'b0 || ir !== mem[m_pc])
          $display("FAIL rnd_exec%0d: ev=%b halted=%b ir=%h, want 1 0 %h", n, exec_valid, halted, ir, mem[m_pc]);
        else passes++;
        br = 1'($urandom); tgt = 8'($urandom);
        done_with(br, tgt);
        m_pc  = br ? tgt : m_pc + 8'd1;
        m_ret = m_ret + 16'd1;
        checks++;
        if (retired !== m_ret) $display("FAIL rnd_retired%0d: ret=%h want %h", n, retired, m_ret);
        else passes++;
      end
    end
  endtask

`ifdef EXEC_DRIVER_STEP_EN
  task automatic test_step();
    do_reset();
    step_mode = 1;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 3; i++) begin
      ack_with(8'h10 + 8'(i)); tick(); done_with(1'b0, 8'h00);
      tick(); tick();
      checks++;
      if (halted !== 1'b1 || exec_valid !== 1'b0 || fetch_req !== 1'b0 || pc !== AW'(i + 1))
        $display("FAIL step_wait%0d: halted=%b ev=%b req=%b pc=%h, want 1 0 0 %h",
                 i, halted, exec_valid, fetch_req, pc, AW'(i + 1));
      else passes++;
      resume = 1; tick(); resume = 0;
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== AW'(i + 1) || halted !== 1'b0)
        $display("FAIL step_resume%0d: req=%b addr=%h halted=%b, want 1 %h 0",
                 i, fetch_req, fetch_addr, halted, AW'(i + 1));
      else passes++;
    end
    step_mode = 0;
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_halt();
    test_resume();
    test_delayed_ack();
    test_branch_wrap();
    test_async_reset();
    test_random();
`ifdef EXEC_DRIVER_STEP_EN
    test_step();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/exec_driver.md
# exec_driver

Instruction sequencer that consumes the halt decoder's run/stop verdict and drives the fetch–decode–execute loop of the tau processor. Sits between instruction memory, the halt decoder (combinational, `run_ok = 0` when the IR holds the halt opcode) and the execute datapath. Owns the PC and IR, stops cleanly on halt, and restarts on a resume pulse.

## Interface
- `OPCODE_SIZE`, 8: instruction/IR width in bits.
- `ADDR_WIDTH`, 8: PC / fetch address width in bits.
- `CNT_WIDTH`, 16: retired-instruction counter width in bits.
- `clk`  in  1: system clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `start`  in  1: pulse; leaves IDLE.
- `resume`  in  1: pulse; leaves HALTED.
- `fetch_req`  out  1: instruction memory request.
- `fetch_addr`  out  ADDR_WIDTH: equals `pc`.
- `fetch_ack`  in  1: memory returns `fetch_data` this cycle.
- `fetch_data`  in  OPCODE_SIZE: instruction word.
- `ir`  out  OPCODE_SIZE: instruction register, feeds the halt decoder.
- `run_ok`  in  1: halt decoder verdict for `ir`; 0 means halt.
- `exec_valid`  out  1: execute datapath may act on `ir`.
- `exec_done`  in  1: datapath finished current instruction.
- `branch_taken`  in  1: qualifies `branch_target`, sampled with `exec_done`.
- `branch_target`  in  ADDR_WIDTH: next PC when the branch is taken.
- `pc`  out  ADDR_WIDTH: program counter.
- `halted`  out  1: high in HALTED.
- `retired`  out  CNT_WIDTH: count of completed instructions.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, HALTED (plus STEP_WAIT, see Configuration).
- Reset: state IDLE. `pc` = 0, `ir` = 0, `retired` = 0. `fetch_req` = 0, `exec_valid` = 0, `halted` = 0.
- IDLE: `start` → FETCH. Other inputs ignored.
- FETCH: `fetch_req` = 1 and `fetch_addr` = `pc`, both held until `fetch_ack`. On `fetch_ack`: `ir` ← `fetch_data`, go to DECODE.
- DECODE: one cycle; `run_ok` is sampled against the new `ir`.
  - `run_ok` = 0 → HALTED, `pc` unchanged (points at the halt instruction).
  - `run_ok` = 1 → EXECUTE.
- EXECUTE: `exec_valid` = 1 until `exec_done`. On `exec_done`:
  - `pc` ← `branch_taken` ? `branch_target` : `pc` + 1.
  - `retired` += 1; go to FETCH.
- HALTED: `halted` = 1. On `resume`: `pc` ← `pc` + 1, go to FETCH. A halt does not increment `retired`.
- Arithmetic: `pc` + 1 wraps modulo 2^ADDR_WIDTH (0xFF → 0x00). `retired` wraps modulo 2^CNT_WIDTH.
- Ignored events, no effect:
  - `start` outside IDLE.
  - `resume` outside HALTED.
  - `fetch_ack` outside FETCH.
  - `exec_done` outside EXECUTE.
- Asynchronous reset mid-operation: immediate return to reset values. An outstanding fetch is abandoned and `fetch_req` drops asynchronously.

## Timing
- All state, `pc`, `ir` and `retired` are registered. Outputs are Moore, decoded from state.
- Minimum instruction period is 3 cycles, for `fetch_ack` in the first FETCH cycle and `exec_done` in the first EXECUTE cycle: FETCH, DECODE, EXECUTE.
- Halt latency: `halted` rises 2 cycles after the `fetch_ack` that loads the halt opcode.
- Resume latency: `fetch_req` rises 1 cycle after `resume`, with the incremented `fetch_addr`.
- `start` → `fetch_req` high the next cycle.

## Configuration
- `EXEC_DRIVER_STEP_EN` defined:
  - Adds input `step_mode` (1 bit) and state STEP_WAIT.
  - With `step_mode` = 1, EXECUTE on `exec_done` goes to STEP_WAIT instead of FETCH.
  - STEP_WAIT: `halted` = 1. A `resume` pulse goes to FETCH without modifying `pc`; `pc` was already updated in EXECUTE.
- Undefined: no `step_mode` port, no STEP_WAIT state; EXECUTE always proceeds to FETCH.

## Structure
- Shared package `tau_pkg`: state enum `exec_state_t`, `HALT_OPCODE` = 8'h01, default widths.
- Single module; no sub-module. Next-PC mux and counter stay inline.

## Test plan
- Reset, `start`, memory returns 0x10 and 0x20 with immediate ack and `exec_done`, then 0x01 → `fetch_addr` sequence 0, 1, 2; `halted` = 1 with `pc` = 2, `retired` = 2.
- While HALTED, pulse `resume` → `fetch_req` next cycle with `fetch_addr` = 3, `halted` = 0.
- `fetch_ack` delayed 4 cycles → `fetch_req` and `fetch_addr` stable throughout; `ir` loads only on ack.
- `exec_done` with `branch_taken` = 1 and `branch_target` = 0x40 → next `fetch_addr` = 0x40. With `pc` = 0xFF and no branch → next `fetch_addr` = 0x00.
- Assert `rst_n` low while in EXECUTE → `exec_valid`, `pc`, `retired` go to 0 immediately; spurious `exec_done` and `resume` in IDLE are ignored.
- `EXEC_DRIVER_STEP_EN` with `step_mode` = 1 → after each `exec_done` the block sits in STEP_WAIT with `halted` = 1; each `resume` advances exactly one instruction.
